// File: rtl/contador_descendente.sv
// rtl/contador_descendente.sv - Loadable down counter with terminal-count pulse
module contador_descendente #(
    parameter int MAXIMA_CUENTA = 28,
    parameter int W             = $clog2(MAXIMA_CUENTA)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         start,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    localparam logic [W-1:0] MAX_VAL = W'(MAXIMA_CUENTA - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] count_next;
    logic [W-1:0] reload_reg, reload_next;
    logic         tc_next;
    logic [W-1:0] load_clamped;

    // Out-of-range load values saturate to the top of the legal count range
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // State, counter, reload value and the registered terminal-count pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= MAX_VAL;
            reload_reg <= MAX_VAL;
            tc         <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
        end
    end

    // Next-state logic: load beats start, start beats counting
    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        if (load) begin
            reload_next = load_clamped;
            count_next  = load_clamped;
            state_next  = IDLE;
        end else if (start && (state != RUN)) begin
            count_next = reload_reg;
            state_next = RUN;
        end else if ((state == RUN) && enable) begin
            if (count != '0) begin
                count_next = count - 1'b1;
            end else begin
                // Terminal edge: pulse tc, then either reload or finish at 0
                tc_next = 1'b1;
                if (auto_reload) begin
                    count_next = reload_reg;
                end else begin
                    state_next = DONE;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_contador_descendente.sv
// tb/tb_contador_descendente.sv - Randomized self-checking bench for contador_descendente
module tb_contador_descendente;

    localparam int MC = 28;
    localparam int W  = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         start;
    logic         load;
    logic [W-1:0] load_val;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=idle 1=run 2=done; count derived from
    // the number of enabled edges taken since the count was started.
    int m_phase;
    int m_r;
    int m_n;
    logic m_tc;

    logic [7:0] got, exp;

    contador_descendente #(.MAXIMA_CUENTA(MC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .load(load),
        .load_val(load_val), .auto_reload(auto_reload), .count(count),
        .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        if (m_phase == 0) return m_r;
        if (m_phase == 1) return m_r - (m_n % (m_r + 1));
        return 0;
    endfunction

    function automatic logic [7:0] m_outputs();
        return {W'(m_count()), m_tc, (m_phase == 1), (m_phase == 2)};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_r     = MC - 1;
        m_n     = 0;
        m_tc    = 1'b0;
    endtask

    task automatic model_edge();
        logic tc_n;
        tc_n = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (load) begin
            m_r     = (int'(load_val) > MC - 1) ? MC - 1 : int'(load_val);
            m_phase = 0;
            m_n     = 0;
        end else if (start && m_phase != 1) begin
            m_phase = 1;
            m_n     = 0;
        end else if (m_phase == 1 && enable) begin
            if (m_count() == 0) begin
                tc_n = 1'b1;
                if (auto_reload) m_n++;
                else m_phase = 2;
            end else begin
                m_n++;
            end
        end
        m_tc = tc_n;
    endtask

    // Advance one clock; sample DUT 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        got = {count, tc, busy, done};
        exp = m_outputs();
    endtask

    task automatic idle_inputs();
        enable = 1'b0; start = 1'b0; load = 1'b0; load_val = '0; auto_reload = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        model_reset();
        tick();
        tick();
        checks++;
        if ({count, tc, busy, done} !== {5'd27, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: got count=%0d tc=%b busy=%b done=%b expected 27/0/0/0", count, tc, busy, done);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (count !== 5'd27 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got count=%0d busy=%b expected 27/0", count, busy);
        end
    endtask

    task automatic test_one_shot();
        int tcs;
        tcs = 0;
        start = 1'b1; enable = 1'b1; auto_reload = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (got !== exp || busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_start: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 28; i++) begin
            tick();
            tcs += int'(tc);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL oneshot_step%0d: got %h expected %h", i, got, exp);
            end
        end
        checks++;
        if (tcs !== 1 || tc !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL oneshot_end: got tcs=%0d tc=%b done=%b busy=%b count=%0d expected 1/1/1/0/0", tcs, tc, done, busy, count);
        end
        tick();
        checks++;
        if (tc !== 1'b0 || done !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL oneshot_after: got tc=%b done=%b count=%0d expected 0/1/0", tc, done, count);
        end
    endtask

    task automatic test_periodic();
        int tcs;
        tcs = 0;
        load_val = 5'd5; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1; auto_reload = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            tcs += int'(tc);
            checks++;
            if (got !== exp || (tc === 1'b1 && count !== 5'd5)) begin
                errors++;
                $display("FAIL periodic_step%0d: got %h expected %h", i, got, exp);
            end
        end
        checks++;
        if (tcs !== 3) begin
            errors++;
            $display("FAIL periodic_tc_count: got %0d expected 3", tcs);
        end
    endtask

    task automatic test_enable_gaps();
        int tcs;
        tcs = 0;
        load_val = 5'd3; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1; auto_reload = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enable = (i % 2 == 0);
            tick();
            tcs += int'(tc);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL gaps_step%0d: got %h expected %h", i, got, exp);
            end
        end
        checks++;
        if (tcs !== 2) begin
            errors++;
            $display("FAIL gaps_tc_count: got %0d expected 2", tcs);
        end
        enable = 1'b0;
    endtask

    task automatic test_clamp_priority();
        load_val = 5'd31; load = 1'b1; start = 1'b1;
        tick();
        checks++;
        if (count !== 5'd27 || busy !== 1'b0 || got !== exp) begin
            errors++;
            $display("FAIL clamp_load: got count=%0d busy=%b expected 27/0", count, busy);
        end
        load = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (count !== 5'd27 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clamp_reload: got count=%0d busy=%b expected 27/1", count, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int guard;
        load_val = 5'd10; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1; auto_reload = 1'b1; enable = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (m_count() != 4 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 40 || count !== 5'd4) begin
            errors++;
            $display("FAIL midrun_reach4: got count=%0d after %0d cycles expected 4", count, guard);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 5'd27 || busy !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL midrun_async: got count=%0d busy=%b tc=%b expected 27/0/0", count, busy, tc);
        end
        tick();
        rst = 1'b1;
        enable = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (count !== 5'd27 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reload: got count=%0d busy=%b expected 27/1", count, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            load        = ($urandom_range(0, 15) == 0);
            start       = ($urandom_range(0, 7) == 0);
            enable      = ($urandom_range(0, 3) != 0);
            auto_reload = ($urandom_range(0, 2) != 0);
            load_val    = W'($urandom_range(0, 31));
            tick();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_step%0d: got %h expected %h", i, got, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_enable_gaps();
        test_clamp_priority();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
